// File: rtl/mux_arb_rr.sv
// mux_arb_rr: N-channel valid/ready arbiter with a registered output stage.
// Selection is fixed priority (lowest index) or round-robin, chosen per cycle
// by rr_en. The round-robin pointer advances past every granted channel in
// both modes, so switching modes never needs a flush.
module mux_arb_rr #(
  parameter int N    = 4,
  parameter int W    = 8,
  parameter int SELW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            rr_en,
  input  logic [N-1:0]    in_valid,
  input  logic [N*W-1:0]  in_data,
  output logic [N-1:0]    in_ready,
  output logic            out_valid,
  output logic [W-1:0]    out_data,
  output logic [SELW-1:0] out_sel,
  input  logic            out_ready
);

  // Channel count and last index at the widths used for pointer arithmetic.
  // The extra bit on the candidate index keeps ptr+k from overflowing before
  // the explicit wrap is applied.
  localparam logic [SELW:0]   N_EXT    = (SELW+1)'(N);
  localparam logic [SELW-1:0] LAST_IDX = SELW'(N-1);

  // Output register and round-robin pointer.
  logic            out_valid_q, out_valid_d;
  logic [W-1:0]    out_data_q,  out_data_d;
  logic [SELW-1:0] out_sel_q,   out_sel_d;
  logic [SELW-1:0] ptr_q,       ptr_d;

  // Arbitration intermediates.
  logic            load_s;
  logic            any_req_s;
  logic            gnt_s;
  logic [SELW-1:0] fp_idx_s;
  logic [SELW-1:0] rr_idx_s;
  logic            rr_found_s;
  logic [SELW:0]   cand_s;
  logic [SELW-1:0] gnt_idx_s;
  logic [N-1:0]    gnt_oh_s;
  logic [W-1:0]    gnt_data_s;

  // Output stage can accept a new item when empty or draining this cycle.
  always_comb begin
    load_s    = (~out_valid_q) | out_ready;
    any_req_s = |in_valid;
  end

  // Fixed priority: scan from the top down so the lowest requesting index
  // is the last one written and therefore wins.
  always_comb begin
    fp_idx_s = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (in_valid[i]) begin
        fp_idx_s = SELW'(i);
      end else begin
        fp_idx_s = fp_idx_s;
      end
    end
  end

  // Round-robin: scan N candidates starting at ptr, wrapping explicitly so
  // a non-power-of-two N never indexes past the last channel.
  always_comb begin
    rr_idx_s   = '0;
    rr_found_s = 1'b0;
    cand_s     = '0;
    for (int k = 0; k < N; k++) begin
      cand_s = {1'b0, ptr_q} + (SELW+1)'(k);
      if (cand_s >= N_EXT) begin
        cand_s = cand_s - N_EXT;
      end else begin
        cand_s = cand_s;
      end
      if (!rr_found_s && in_valid[cand_s[SELW-1:0]]) begin
        rr_found_s = 1'b1;
        rr_idx_s   = cand_s[SELW-1:0];
      end else begin
        rr_found_s = rr_found_s;
      end
    end
  end

  // Grant selection. Grants are suppressed while rst_n is low so nothing is
  // offered upstream during reset. Only the granted slice of in_data is
  // read, so unknowns on idle channels never reach the output register.
  always_comb begin
    gnt_s      = load_s & any_req_s & rst_n;
    gnt_idx_s  = rr_en ? rr_idx_s : fp_idx_s;
    gnt_oh_s   = {{(N-1){1'b0}}, 1'b1} << gnt_idx_s;
    gnt_data_s = in_data[gnt_idx_s*W +: W];
    if (gnt_s) begin
      in_ready = gnt_oh_s;
    end else begin
      in_ready = '0;
    end
  end

  // Next-state for the output register and pointer. A grant always implies
  // a transfer because the granted channel has in_valid set.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    ptr_d       = ptr_q;
    if (gnt_s) begin
      out_valid_d = 1'b1;
      out_data_d  = gnt_data_s;
      out_sel_d   = gnt_idx_s;
      if (gnt_idx_s == LAST_IDX) begin
        ptr_d = '0;
      end else begin
        ptr_d = gnt_idx_s + SELW'(1);
      end
    end else if (load_s) begin
      // Drained (or still empty): data and index keep their last values.
      out_valid_d = 1'b0;
    end else begin
      // Stalled by the consumer: everything holds.
      out_valid_d = out_valid_q;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      ptr_q       <= ptr_d;
    end
  end

  // Registered outputs driven straight from the flops.
  always_comb begin
    out_valid = out_valid_q;
    out_data  = out_data_q;
    out_sel   = out_sel_q;
  end

endmodule
